ddr3_app_responder: RTL



---
 rtl/ddr3_app_pkg.sv | 42 ++++
 rtl/ddr3_rd_return_queue.sv | 60 ++++++
 rtl/ddr3_app_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 user-interface responder.
// Provides command encodings, bus widths, the pixel packing of a 128-bit
// word (pixel 0 in bits [15:0]), the FSM state type and the masked-merge helper.
package ddr3_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int unsigned DATA_W       = 128;
    localparam int unsigned MASK_W       = 16;
    localparam int unsigned PIX_W        = 16;
    localparam int unsigned PIX_PER_WORD = DATA_W / PIX_W;

    // Eight 16-bit pixels per memory word, pixel 0 in the least significant slot.
    typedef logic [PIX_PER_WORD-1:0][PIX_W-1:0] pix_word_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT_WDATA
    } resp_state_t;

    // One write-data beat as presented on the user interface.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } wr_beat_t;

    // Merge a beat into an existing word; a set mask bit keeps the old byte.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input wr_beat_t          beat);
        logic [DATA_W-1:0] w;
        w = old_word;
        for (int i = 0; i < int'(MASK_W); i++) begin
            if (!beat.mask[i]) begin
                w[8*i +: 8] = beat.data[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ddr3_rd_return_queue.sv
// Read-return FIFO: holds read data tagged with the timestamp at which it
// must be presented. A small free-running timestamp replaces a full-width
// data delay line.
// Ports: clk/rst_n; push + push_data (entry arrives one cycle after the read
// accept); pop; head_data_c / due_c (head entry and "release now" flag).
module ddr3_rd_return_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned LATENCY = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data_c,
    output logic              due_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TS_W  = $clog2(LATENCY) + 2;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TS_W-1:0]   ts_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [TS_W-1:0]   ts_q;

    // Pointers, occupancy and the free-running timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_q     <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; the push lands one cycle after accept, hence LATENCY-1.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= push_data;
            ts_mem[wr_ptr_q]   <= ts_q + TS_W'(LATENCY - 1);
        end
    end

    assign head_data_c = data_mem[rd_ptr_q];
    assign due_c       = (count_q != '0) && (ts_mem[rd_ptr_q] == ts_q);

endmodule

// File: rtl/ddr3_app_responder.sv
// BRAM-backed stand-in for the DDR3 controller user-side interface.
// Reproduces calibration delay, fixed read latency, ready backpressure,
// the outstanding-read limit and optional periodic stalls.
// Ports: clk/rst_n; cmd_en/cmd/addr/cmd_ready (command channel);
// wr_data_en/wr_data/wr_data_end/wr_data_mask/wr_data_rdy (write data);
// rd_data/rd_data_valid/rd_data_end (read return); init_calib_complete; err.
module ddr3_app_responder
    import ddr3_app_pkg::*;
#(
    parameter int unsigned ADDR_W          = 28,
    parameter int unsigned WORDS_LOG2      = 15,
    parameter int unsigned RD_LATENCY      = 22,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned INIT_CYCLES     = 64,
    parameter int unsigned STALL_PERIOD    = 0,
    parameter int unsigned STALL_LEN       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_en,
    input  logic [2:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    output logic              cmd_ready,
    input  logic              wr_data_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_end,
    input  logic [MASK_W-1:0] wr_data_mask,
    output logic              wr_data_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_data_end,
    output logic              init_calib_complete,
    output logic              err
);

    localparam int unsigned DEPTH   = 1 << WORDS_LOG2;
    localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned INIT_W  = $clog2(INIT_CYCLES + 1);
    localparam int unsigned STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    resp_state_t           state_q, state_nx;
    logic [INIT_W-1:0]     init_cnt_q, init_cnt_nx;
    logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_nx;
    logic [OUT_W-1:0]      outst_q, outst_nx;
    logic [WORDS_LOG2-1:0] wr_addr_q, wr_addr_nx;
    logic                  err_q, err_nx;
    logic                  cmd_ready_q, cmd_ready_nx;
    logic                  wr_data_rdy_q, wr_data_rdy_nx;
    logic                  init_done_q;
    logic                  rd_vld_q;
    logic [DATA_W-1:0]     rd_word_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  rd_data_valid_q;
    logic                  stall_win_nx;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  mem_we_c;
    logic [WORDS_LOG2-1:0] mem_waddr_c;

    logic                  cmd_acc_c, wr_acc_c, aligned_c;
    logic                  wr_cmd_c, rd_cmd_c, bad_cmd_c;
    logic [WORDS_LOG2-1:0] cmd_word_c;
    wr_beat_t              wr_beat_c;
    logic [DATA_W-1:0]     q_head_c;
    logic                  q_due_c;
    logic                  unused_addr_c;

    // Command decode; upper address bits beyond the BRAM wrap.
    assign cmd_acc_c     = cmd_en && cmd_ready_q;
    assign wr_acc_c      = wr_data_en && wr_data_rdy_q;
    assign aligned_c     = (addr[2:0] == 3'b000);
    assign cmd_word_c    = addr[WORDS_LOG2+2:3];
    assign wr_cmd_c      = cmd_acc_c && aligned_c && (cmd == CMD_WRITE);
    assign rd_cmd_c      = cmd_acc_c && aligned_c && (cmd == CMD_READ);
    assign bad_cmd_c     = cmd_acc_c && !(wr_cmd_c || rd_cmd_c);
    assign wr_beat_c     = '{data: wr_data, mask: wr_data_mask};
    assign unused_addr_c = ^addr[ADDR_W-1:WORDS_LOG2+3];

    // Next-state and next-output logic; ready flags are registered from next values.
    always_comb begin
        state_nx     = state_q;
        init_cnt_nx  = init_cnt_q;
        wr_addr_nx   = wr_addr_q;
        err_nx       = err_q;
        outst_nx     = outst_q;
        stall_cnt_nx = '0;
        mem_we_c     = 1'b0;
        mem_waddr_c  = cmd_word_c;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) state_nx = ST_IDLE;
                else                                       init_cnt_nx = init_cnt_q + INIT_W'(1);
            end
            ST_IDLE: begin
                if (wr_cmd_c) begin
                    if (wr_acc_c) begin
                        mem_we_c = 1'b1;
                    end else begin
                        state_nx   = ST_WAIT_WDATA;
                        wr_addr_nx = cmd_word_c;
                    end
                end else if (wr_acc_c) begin
                    err_nx = 1'b1;  // orphan write data is dropped
                end
            end
            ST_WAIT_WDATA: begin
                if (wr_acc_c) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = wr_addr_q;
                    state_nx    = ST_IDLE;
                end
            end
            default: state_nx = ST_INIT;
        endcase

        if (bad_cmd_c || (wr_acc_c && !wr_data_end)) err_nx = 1'b1;

        case ({rd_cmd_c, q_due_c})
            2'b10:   outst_nx = outst_q + OUT_W'(1);
            2'b01:   outst_nx = outst_q - OUT_W'(1);
            default: outst_nx = outst_q;
        endcase

        if (STALL_PERIOD != 0) begin
            stall_cnt_nx = (stall_cnt_q == STALL_W'(STALL_PERIOD - 1)) ? '0
                                                                       : stall_cnt_q + STALL_W'(1);
        end
        stall_win_nx = (STALL_PERIOD != 0) && (stall_cnt_nx < STALL_W'(STALL_LEN));

        cmd_ready_nx   = (state_nx == ST_IDLE) && (outst_nx < OUT_W'(MAX_OUTSTANDING)) && !stall_win_nx;
        wr_data_rdy_nx = ((state_nx == ST_IDLE) || (state_nx == ST_WAIT_WDATA)) && !stall_win_nx;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_INIT;
            init_cnt_q      <= '0;
            stall_cnt_q     <= '0;
            outst_q         <= '0;
            wr_addr_q       <= '0;
            err_q           <= 1'b0;
            cmd_ready_q     <= 1'b0;
            wr_data_rdy_q   <= 1'b0;
            init_done_q     <= 1'b0;
            rd_vld_q        <= 1'b0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_nx;
            init_cnt_q      <= init_cnt_nx;
            stall_cnt_q     <= stall_cnt_nx;
            outst_q         <= outst_nx;
            wr_addr_q       <= wr_addr_nx;
            err_q           <= err_nx;
            cmd_ready_q     <= cmd_ready_nx;
            wr_data_rdy_q   <= wr_data_rdy_nx;
            init_done_q     <= (state_nx != ST_INIT);
            rd_vld_q        <= rd_cmd_c;
            rd_data_valid_q <= q_due_c;
            if (q_due_c) rd_data_q <= q_head_c;
        end
    end

    // BRAM: masked write port plus synchronous read for accepted reads.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_waddr_c] <= merge_bytes(mem[mem_waddr_c], wr_beat_c);
        if (rd_cmd_c) rd_word_q <= mem[cmd_word_c];
    end

    ddr3_rd_return_queue #(
        .DEPTH   (MAX_OUTSTANDING),
        .DATA_W  (DATA_W),
        .LATENCY (RD_LATENCY)
    ) u_rd_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (rd_vld_q),
        .push_data   (rd_word_q),
        .pop         (q_due_c),
        .head_data_c (q_head_c),
        .due_c       (q_due_c)
    );

    assign cmd_ready           = cmd_ready_q;
    assign wr_data_rdy         = wr_data_rdy_q;
    assign rd_data             = rd_data_q;
    assign rd_data_valid       = rd_data_valid_q;
    assign rd_data_end         = rd_data_valid_q;
    assign init_calib_complete = init_done_q;
    assign err                 = err_q;

endmodule
